prio_enc_rr: RTL and testbench
==============================

Name: prio_enc_rr

Overview:
- Parametrised N-to-log2(N) request encoder; successor to the team's fixed 8-to-3 behavioural encoder.
- Adds registered output, fixed-priority or round-robin selection, and a valid/ready output handshake.
- A multi-request flag replaces undefined behaviour on non-one-hot input.
- Sits between request sources (interrupt lines, channel requests) and a single consumer that takes one index per transfer.

Parameters:
- N, 8, number of request lines; 2..64; need not be a power of 2.
- W, $clog2(N), index width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  encoder enable; 0 blocks new captures but does not drop a held result.
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- req  input  N  request vector, sampled each cycle.
- idx  output  W  encoded index of the captured request.
- valid  output  1  idx holds an unconsumed result.
- ready  input  1  consumer accepts idx when valid && ready.
- multi  output  1  more than one req bit was set at capture.
- ptr  output  W  current round-robin base pointer (debug/visibility).

Behaviour:
- Reset (rst_n=0, async): idx=0, valid=0, multi=0, ptr=0. Release is synchronous to clk.
- Accept: acc = valid && ready.
- Load condition: ld = en && (req != 0) && (!valid || ready).
- Latency and throughput: 1 cycle from sampled req to valid; back-to-back loads allowed, giving one result per cycle under continuous ready.
- On ld:
  - idx = selected index; valid=1.
  - multi = (popcount(req) > 1).
- On acc && !ld: valid=0; idx and multi hold their last value.
- Hold: while valid && !ready, idx/valid/multi are stable regardless of req, en or mode.
- Fixed-priority select: lowest set bit index of req.
- Round-robin select: lowest set index i with i >= ptr; if none, lowest set index overall (wrap).
- Pointer update: only on acc with mode=1, ptr = (idx == N-1) ? 0 : idx+1. Non-power-of-2 N wraps at N-1, never reaching N.
- Mode=0 leaves ptr unchanged.
- Simultaneous acc and ld:
  - Selection uses the pre-update ptr.
  - ptr advances from the accepted idx.
  - The new idx is loaded in the same edge.
- Mode change: takes effect at the next ld; a held result is unaffected.
- req==0 or en==0: no load; a pending valid stays until accepted.
- Reset mid-transfer: valid drops immediately (async); the pending result is lost.
- Single-bit req in either mode: idx equals that bit's position (one-hot compatibility).

Decomposition:
- Shared package enc_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - A function for clog2-based width, shared by future encoders.
- Sub-module prio_find (combinational): inputs vec[N], base[W]; outputs found, pos[W].
  - Masked lowest-set search with wrap.
  - Fixed mode instantiates it with base=0, so one instance serves both modes.
- Top level holds the output register, handshake and pointer logic.

Test Plan:
- Reset then single-bit sweep: N=8, mode=0, ready=1, req=1<<k for k=0..7 -> idx=k one cycle later, valid=1, multi=0.
- Fixed priority: req=8'b1010_0100, mode=0 -> idx=2, multi=1; repeat -> idx=2 again, ptr stays 0.
- Round-robin: req held 8'b1000_0101, mode=1, ready=1 -> successive idx 0,2,7,0; ptr 1,3,0,1.
- Backpressure: load idx=3, ready=0 for 5 cycles while req changes to 8'h01 -> idx=3, valid=1 stable; ready=1 -> next cycle idx=0.
- Non-power-of-2 wrap: N=5, mode=1, req=5'b10001 -> idx 0,4,0; ptr 1,0,1; ptr never equals 5.
- Async reset: assert rst_n=0 mid-cycle with valid=1 -> valid=0, idx=0, ptr=0 before next clk edge; en=0 with req!=0 -> valid stays 0.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared definitions for the request encoder family.
// Provides mode encodings and the index-width helper used to size
// index and pointer ports from the request count.
package enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for an n-line encoder. This is ceil(log2(n)), kept at a
  // minimum of one bit so that degenerate sizes still get a legal vector.
  function automatic int enc_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc_rr_if.sv
// Output handshake bundle of prio_enc_rr.
//   idx   : encoded index of the captured request
//   valid : idx holds an unconsumed result
//   ready : consumer accepts idx when valid && ready
//   multi : more than one request bit was set at capture
// The master modport is the encoder; the slave modport is the consumer.
interface prio_enc_rr_if
  import enc_pkg::*;
#(
  parameter int N = 8
);
  localparam int W = enc_width(N);

  logic [W-1:0] idx;
  logic         valid;
  logic         ready;
  logic         multi;

  modport master (output idx, output valid, output multi, input ready);
  modport slave  (input idx, input valid, input multi, output ready);

endinterface

// File: rtl/prio_find.sv
// Combinational lowest-set-bit search with a movable base and wrap-around.
//   vec   : candidate bits
//   base  : search starts at this position
//   found : at least one bit of vec is set
//   pos   : lowest set position >= base; if there is none, the lowest set
//           position overall. pos is 0 when found is 0.
// A base of 0 degenerates to plain fixed priority, so a single instance
// serves both selection modes.
module prio_find
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = enc_width(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] base,
  output logic         found,
  output logic [W-1:0] pos
);

  logic         hit_hi;
  logic [W-1:0] pos_hi;
  logic [W-1:0] pos_lo;

  // Walking from the top down means the last match written is the lowest.
  always_comb begin
    hit_hi = 1'b0;
    pos_hi = '0;
    pos_lo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        pos_lo = W'(i);
        if (i >= int'(base)) begin
          hit_hi = 1'b1;
          pos_hi = W'(i);
        end
      end
    end
    found = |vec;
    pos   = hit_hi ? pos_hi : pos_lo;
  end

endmodule

// File: rtl/prio_enc_rr.sv
// Registered N-to-log2(N) request encoder with fixed-priority or
// round-robin selection and a valid/ready output handshake.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   en    : enable; 0 blocks new captures but keeps a held result
//   mode  : MODE_FIXED (lowest index wins) or MODE_RR (round-robin)
//   req   : request vector, sampled every cycle
//   ptr   : round-robin base pointer, exported for visibility
//   bus   : idx / valid / multi out, ready in
module prio_enc_rr
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = enc_width(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        req,
  output logic [W-1:0]        ptr,
  prio_enc_rr_if.master       bus
);

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);
  localparam logic [N-1:0] ONE_N    = N'(1);

  logic         acc;
  logic         ld;
  logic         found;
  logic [W-1:0] sel;
  logic [W-1:0] base;
  logic         multi_now;

  assign acc = bus.valid && bus.ready;
  assign ld  = en && (req != '0) && (!bus.valid || bus.ready);

  // Selection always uses the pointer as it stands before this edge, even
  // when the same edge also accepts a result and advances the pointer.
  assign base = (mode == MODE_RR) ? ptr : '0;

  prio_find #(.N(N)) u_find (
    .vec   (req),
    .base  (base),
    .found (found),
    .pos   (sel)
  );

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_now = |(req & (req - ONE_N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.idx   <= '0;
      bus.valid <= 1'b0;
      bus.multi <= 1'b0;
    end else if (ld && found) begin
      bus.idx   <= sel;
      bus.valid <= 1'b1;
      bus.multi <= multi_now;
    end else if (acc) begin
      bus.valid <= 1'b0;
    end
  end

  // The pointer follows the index that was handed over, wrapping at N-1
  // so that non-power-of-two sizes never point past the last line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (acc && (mode == MODE_RR)) begin
      ptr <= (bus.idx == LAST_IDX) ? '0 : bus.idx + W'(1);
    end
  end

endmodule

// File: tb/tb_prio_enc_rr.sv
module tb_prio_enc_rr;
  import enc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       en8 = 1'b0;
  logic       mode8 = MODE_FIXED;
  logic [7:0] req8 = '0;
  logic [2:0] ptr8;

  logic       en5 = 1'b0;
  logic       mode5 = MODE_FIXED;
  logic [4:0] req5 = '0;
  logic [2:0] ptr5;

  int vectors = 0;
  int miscompares = 0;

  prio_enc_rr_if #(.N(8)) if8 ();
  prio_enc_rr_if #(.N(5)) if5 ();

  prio_enc_rr #(.N(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en8),
    .mode  (mode8),
    .req   (req8),
    .ptr   (ptr8),
    .bus   (if8)
  );

  prio_enc_rr #(.N(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en5),
    .mode  (mode5),
    .req   (req5),
    .ptr   (ptr5),
    .bus   (if5)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One round-robin transfer on dut8: capture with ready low, then accept
  // with en low so that only the pointer moves on the second edge.
  task automatic rr_xfer(input logic [2:0] exp_idx, input logic [2:0] exp_ptr);
    mode8 = MODE_RR;
    en8 = 1'b1;
    if8.ready = 1'b0;
    tick();
    check("rr_idx", 32'(if8.idx), 32'(exp_idx));
    check("rr_valid", 32'(if8.valid), 32'd1);
    en8 = 1'b0;
    if8.ready = 1'b1;
    tick();
    check("rr_ptr", 32'(ptr8), 32'(exp_ptr));
    check("rr_drain", 32'(if8.valid), 32'd0);
  endtask

  initial begin
    logic [2:0] exp5_idx [3];
    logic [2:0] exp5_ptr [3];
    exp5_idx = '{3'd0, 3'd4, 3'd0};
    exp5_ptr = '{3'd1, 3'd0, 3'd1};

    if8.ready = 1'b0;
    if5.ready = 1'b0;

    // Reset state
    #12;
    check("rst_idx", 32'(if8.idx), 32'd0);
    check("rst_valid", 32'(if8.valid), 32'd0);
    check("rst_multi", 32'(if8.multi), 32'd0);
    check("rst_ptr", 32'(ptr8), 32'd0);
    tick();
    rst_n = 1'b1;

    // Single-bit sweep, fixed priority, continuous ready
    mode8 = MODE_FIXED;
    en8 = 1'b1;
    if8.ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req8 = 8'(1 << k);
      tick();
      check("sweep_idx", 32'(if8.idx), 32'(k));
      check("sweep_valid", 32'(if8.valid), 32'd1);
      check("sweep_multi", 32'(if8.multi), 32'd0);
    end
    check("sweep_ptr", 32'(ptr8), 32'd0);

    // Fixed priority with several requests
    req8 = 8'b1010_0100;
    tick();
    check("fix_idx", 32'(if8.idx), 32'd2);
    check("fix_multi", 32'(if8.multi), 32'd1);
    tick();
    check("fix_idx2", 32'(if8.idx), 32'd2);
    check("fix_ptr", 32'(ptr8), 32'd0);

    // Drain in fixed mode so the pointer stays at 0
    req8 = '0;
    tick();
    check("drain_valid", 32'(if8.valid), 32'd0);
    check("drain_ptr", 32'(ptr8), 32'd0);

    // Round-robin, one transfer at a time
    req8 = 8'b1000_0101;
    rr_xfer(3'd0, 3'd1);
    rr_xfer(3'd2, 3'd3);
    rr_xfer(3'd7, 3'd0);
    rr_xfer(3'd0, 3'd1);

    // Back-to-back round-robin: selection sees the pre-update pointer
    mode8 = MODE_RR;
    en8 = 1'b1;
    if8.ready = 1'b1;
    tick();
    check("b2b_idx_a", 32'(if8.idx), 32'd2);
    check("b2b_ptr_a", 32'(ptr8), 32'd1);
    tick();
    check("b2b_idx_b", 32'(if8.idx), 32'd2);
    check("b2b_ptr_b", 32'(ptr8), 32'd3);
    tick();
    check("b2b_idx_c", 32'(if8.idx), 32'd7);
    check("b2b_ptr_c", 32'(ptr8), 32'd3);
    tick();
    check("b2b_idx_d", 32'(if8.idx), 32'd7);
    check("b2b_ptr_d", 32'(ptr8), 32'd0);
    en8 = 1'b0;
    tick();
    check("b2b_drain", 32'(if8.valid), 32'd0);
    check("b2b_ptr_e", 32'(ptr8), 32'd0);

    // Backpressure: held result ignores req and mode changes
    mode8 = MODE_FIXED;
    en8 = 1'b1;
    if8.ready = 1'b0;
    req8 = 8'h08;
    tick();
    check("bp_load", 32'(if8.idx), 32'd3);
    req8 = 8'h01;
    for (int c = 0; c < 5; c++) begin
      mode8 = (c % 2 == 1) ? MODE_RR : MODE_FIXED;
      tick();
      check("bp_idx", 32'(if8.idx), 32'd3);
      check("bp_valid", 32'(if8.valid), 32'd1);
    end
    mode8 = MODE_FIXED;
    if8.ready = 1'b1;
    tick();
    check("bp_release", 32'(if8.idx), 32'd0);
    check("bp_rel_valid", 32'(if8.valid), 32'd1);
    check("bp_ptr", 32'(ptr8), 32'd0);

    // Build a non-zero state, then reset asynchronously mid-cycle
    mode8 = MODE_RR;
    req8 = 8'h40;
    en8 = 1'b0;
    tick();
    check("pre_ptr", 32'(ptr8), 32'd1);
    en8 = 1'b1;
    if8.ready = 1'b0;
    tick();
    check("pre_idx", 32'(if8.idx), 32'd6);
    check("pre_valid", 32'(if8.valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(if8.valid), 32'd0);
    check("arst_idx", 32'(if8.idx), 32'd0);
    check("arst_ptr", 32'(ptr8), 32'd0);
    en8 = 1'b0;
    req8 = 8'hff;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("en0_valid", 32'(if8.valid), 32'd0);

    // Non-power-of-two wrap with N=5
    req5 = 5'b10001;
    mode5 = MODE_RR;
    for (int t = 0; t < 3; t++) begin
      en5 = 1'b1;
      if5.ready = 1'b0;
      tick();
      check("n5_idx", 32'(if5.idx), 32'(exp5_idx[t]));
      en5 = 1'b0;
      if5.ready = 1'b1;
      tick();
      check("n5_ptr", 32'(ptr5), 32'(exp5_ptr[t]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
